// File: rtl/snn_pkg.sv
// Shared float32 field constants, adder threshold and sequencer state encoding
// for the LIF neuron pipeline.
package snn_pkg;

    localparam int unsigned FP_W    = 32;
    localparam int unsigned EXP_MSB = 30;
    localparam int unsigned EXP_LSB = 23;
    localparam int unsigned EXP_W   = EXP_MSB - EXP_LSB + 1;
    localparam int unsigned MAN_W   = EXP_LSB;

    localparam logic [EXP_W-1:0] EXP_INF     = 8'hFF;
    localparam logic [FP_W-1:0]  FP_ZERO     = 32'h0000_0000;
    localparam logic [FP_W-1:0]  V_THRESHOLD = 32'h4220_0000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exponent;
        logic [MAN_W-1:0] mantissa;
    } fp32_t;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_IDLE  = 3'd2,
        ST_FETCH = 3'd3,
        ST_ISSUE = 3'd4,
        ST_WAIT  = 3'd5,
        ST_WB    = 3'd6,
        ST_DONE  = 3'd7
    } seq_state_e;

endpackage

// File: rtl/neuron_timestep_sequencer_if.sv
// Weight-fetch and adder-operand bus between the timestep sequencer (master)
// and the weight store / LIF potential adder (slave).
interface neuron_timestep_sequencer_if #(
    parameter int unsigned NUM_NEURONS = 30
);
    localparam int unsigned IDX_W = $clog2(NUM_NEURONS);

    logic             weight_req;
    logic [IDX_W-1:0] neuron_idx;
    logic             weight_valid;
    logic [31:0]      weight_data;
    logic             set_adder;
    logic             clear_adder;
    logic [31:0]      input_weight;
    logic [31:0]      decayed_potential;
    logic [31:0]      final_potential;
    logic             spike_in;

    modport master (
        output weight_req, neuron_idx, set_adder, clear_adder,
               input_weight, decayed_potential,
        input  weight_valid, weight_data, final_potential, spike_in
    );

    modport slave (
        input  weight_req, neuron_idx, set_adder, clear_adder,
               input_weight, decayed_potential,
        output weight_valid, weight_data, final_potential, spike_in
    );

endinterface

// File: rtl/fp32_pow2_decay.sv
// Combinational float32 multiply by 2^-DECAY_SHIFT via exponent subtraction;
// inf/NaN pass through, results that would underflow flush to +0.0.
module fp32_pow2_decay
    import snn_pkg::*;
#(
    parameter int unsigned DECAY_SHIFT = 1
) (
    input  logic [FP_W-1:0] value,
    output logic [FP_W-1:0] decayed_c
);

    fp32_t v;
    fp32_t r;

    always_comb begin
        v = fp32_t'(value);
        r = v;
        if (v.exponent == EXP_INF) begin
            r = v;
        end else if (32'(v.exponent) <= DECAY_SHIFT) begin
            r = fp32_t'(FP_ZERO);
        end else begin
            r.exponent = v.exponent - EXP_W'(DECAY_SHIFT);
        end
    end

    assign decayed_c = r;

endmodule

// File: rtl/neuron_timestep_sequencer.sv
// Time-multiplexes NUM_NEURONS membrane potentials onto one LIF adder: decay,
// fetch weight, issue operands, write back result, publish the spike vector.
module neuron_timestep_sequencer
    import snn_pkg::*;
#(
    parameter int unsigned NUM_NEURONS   = 30,
    parameter int unsigned DECAY_SHIFT   = 1,
    parameter int unsigned ADDER_LATENCY = 1
) (
    input  logic                         CLK,
    input  logic                         RESETn,
    input  logic                         start_timestep,
    input  logic                         init_req,
    neuron_timestep_sequencer_if.master  bus,
    output logic [NUM_NEURONS-1:0]       spike_vec,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned IDX_W = $clog2(NUM_NEURONS);
    localparam int unsigned LAT_W = (ADDER_LATENCY > 1) ? $clog2(ADDER_LATENCY) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
    localparam logic [LAT_W-1:0] LAST_WAIT = LAT_W'(ADDER_LATENCY - 1);

    seq_state_e state;
    seq_state_e state_next;

    logic [IDX_W-1:0]       idx;
    logic [LAT_W-1:0]       wait_cnt;
    logic [FP_W-1:0]        res_q;
    logic                   spk_q;
    logic [NUM_NEURONS-1:0] spike_acc;
    logic [NUM_NEURONS-1:0] spike_merged;
    logic [FP_W-1:0]        mem [NUM_NEURONS];
    logic [FP_W-1:0]        cur_potential;
    logic [FP_W-1:0]        decay_c;

    logic             weight_req_q, set_adder_q, clear_adder_q;
    logic [FP_W-1:0]  input_weight_q, decayed_potential_q;
    logic             weight_req_d, set_adder_d, clear_adder_d, busy_d, done_d;
    logic             mem_we;
    logic [FP_W-1:0]  mem_wdata;

    assign cur_potential = mem[idx];

    fp32_pow2_decay #(.DECAY_SHIFT(DECAY_SHIFT)) u_decay (
        .value     (cur_potential),
        .decayed_c (decay_c)
    );

    // State register
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) state <= ST_INIT;
        else         state <= state_next;
    end

    // Next-state logic; init_req has priority over start_timestep in IDLE
    always_comb begin
        state_next = state;
        unique case (state)
            ST_INIT:  if (idx == LAST_IDX) state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_IDLE;
            ST_IDLE: begin
                if (init_req)            state_next = ST_INIT;
                else if (start_timestep) state_next = ST_FETCH;
            end
            ST_FETCH: if (bus.weight_valid) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  if (wait_cnt == LAST_WAIT) state_next = ST_WB;
            ST_WB:    state_next = (idx == LAST_IDX) ? ST_DONE : ST_FETCH;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_INIT;
        endcase
    end

    // Output decode on the next state so the registered outputs line up with it
    always_comb begin
        weight_req_d  = (state_next == ST_FETCH);
        set_adder_d   = (state_next == ST_LOAD);
        clear_adder_d = (state == ST_IDLE) && (state_next == ST_FETCH);
        busy_d        = (state_next != ST_IDLE);
        done_d        = (state_next == ST_LOAD) || (state_next == ST_DONE);
        mem_we        = 1'b0;
        mem_wdata     = FP_ZERO;
        if (state == ST_INIT) begin
            mem_we    = 1'b1;
        end else if (state == ST_WB) begin
            mem_we    = 1'b1;
            mem_wdata = res_q;
        end
    end

    always_comb begin
        spike_merged      = spike_acc;
        spike_merged[idx] = spk_q;
    end

    // Index, wait counter, operand/result capture and registered outputs
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            idx                 <= '0;
            wait_cnt            <= '0;
            res_q               <= FP_ZERO;
            spk_q               <= 1'b0;
            spike_acc           <= '0;
            spike_vec           <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
            weight_req_q        <= 1'b0;
            set_adder_q         <= 1'b0;
            clear_adder_q       <= 1'b0;
            input_weight_q      <= FP_ZERO;
            decayed_potential_q <= FP_ZERO;
        end else begin
            busy          <= busy_d;
            done          <= done_d;
            weight_req_q  <= weight_req_d;
            set_adder_q   <= set_adder_d;
            clear_adder_q <= clear_adder_d;
            unique case (state)
                ST_INIT:  idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
                ST_IDLE:  idx <= '0;
                ST_FETCH: begin
                    if (bus.weight_valid) begin
                        input_weight_q      <= bus.weight_data;
                        decayed_potential_q <= decay_c;
                    end
                end
                ST_ISSUE: wait_cnt <= '0;
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + LAT_W'(1);
                    if (wait_cnt == LAST_WAIT) begin
                        res_q <= bus.final_potential;
                        spk_q <= bus.spike_in;
                    end
                end
                ST_WB: begin
                    spike_acc[idx] <= spk_q;
                    if (idx == LAST_IDX) spike_vec <= spike_merged;
                    else                 idx <= idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Potential store: no reset, contents defined once INIT has swept it
    always_ff @(posedge CLK) begin
        if (mem_we) mem[idx] <= mem_wdata;
    end

    assign bus.weight_req        = weight_req_q;
    assign bus.neuron_idx        = idx;
    assign bus.set_adder         = set_adder_q;
    assign bus.clear_adder       = clear_adder_q;
    assign bus.input_weight      = input_weight_q;
    assign bus.decayed_potential = decayed_potential_q;

endmodule

// File: tb/tb_neuron_timestep_sequencer.sv
// Directed bench for neuron_timestep_sequencer with a float LIF adder model
// (reset-by-subtraction at a 40.0 threshold) on the adder side of the bus.
module tb_neuron_timestep_sequencer;
    import snn_pkg::*;

    localparam int unsigned N = 30;
    localparam int unsigned L = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_timestep = 1'b0;
    logic          init_req = 1'b0;
    logic [N-1:0]  spike_vec;
    logic          busy;
    logic          done;
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    real           sum;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    neuron_timestep_sequencer_if #(.NUM_NEURONS(N)) bus ();

    neuron_timestep_sequencer #(
        .NUM_NEURONS(N), .DECAY_SHIFT(1), .ADDER_LATENCY(L)
    ) dut (
        .CLK(clk), .RESETn(rst_n), .start_timestep(start_timestep),
        .init_req(init_req), .bus(bus), .spike_vec(spike_vec),
        .busy(busy), .done(done)
    );

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'h00) return 0.0;
        d = {f[31], (f[30:23] == 8'hFF) ? 11'h7FF : 11'(f[30:23]) + 11'd896, f[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:52] == 11'h000) return 32'h0;
        if (d[62:52] == 11'h7FF) return {d[63], 8'hFF, d[51:29]};
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    // LIF adder model: spike when strictly above threshold, then subtract it
    always_comb begin
        sum = f2r(bus.decayed_potential) + f2r(bus.input_weight);
        bus.spike_in        = (sum > f2r(V_THRESHOLD));
        bus.final_potential = bus.spike_in ? r2f(sum - f2r(V_THRESHOLD)) : r2f(sum);
    end

    function automatic logic [31:0] w(input int t, input int n);
        if (n == 0 && t == 1) return 32'h41A0_0000;
        if (n == 0 && (t == 2 || t == 3)) return 32'h41F0_0000;
        if (t == 1 && n == 1) return 32'h0080_0000;
        if (t == 1 && n == 2) return 32'hC1A0_0000;
        if (t == 1 && n == 3) return 32'h7F80_0000;
        if (t == 3 && n == 6) return 32'h3F80_0000;
        return 32'h0;
    endfunction

    // Hand-computed decayed potentials seen at ISSUE
    function automatic logic [31:0] exp_dec(input int t, input int n);
        case (t)
            2: case (n) 0: return 32'h4120_0000; 2: return 32'hC120_0000;
                        3: return 32'h7F80_0000; default: return 32'h0; endcase
            3: case (n) 0: return 32'h41A0_0000; 2: return 32'hC0A0_0000;
                        3: return 32'h7F80_0000; default: return 32'h0; endcase
            4: case (n) 0: return 32'h40A0_0000; 2: return 32'hC020_0000;
                        3: return 32'h7F80_0000; 6: return 32'h3F00_0000;
                        default: return 32'h0; endcase
            default: return 32'h0;
        endcase
    endfunction

    // Spike vector after timestep t (t=4 is aborted by reset, so 0)
    function automatic logic [31:0] exp_vec(input int t);
        case (t)
            1, 2: return 32'h0000_0008;
            3:    return 32'h0000_0009;
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic wait_init(input int exp_cycles);
        int k;
        k = 0;
        do begin @(negedge clk); k++; end while (!done && k < 100);
        check("init_len", 32'(k), 32'(exp_cycles));
        check("init_set_adder", 32'(bus.set_adder), 1);
        check("init_no_clear", 32'(bus.clear_adder), 0);
        check("init_no_req", 32'(bus.weight_req), 0);
        @(negedge clk);
        check("init_done_pulse", 32'(done), 0);
        check("init_idle", 32'(busy), 0);
        check("init_set_drop", 32'(bus.set_adder), 0);
    endtask

    task automatic run_timestep(input int t, input int delay_n, input int delay_cycles, input int stop_at);
        int k;
        int c0;
        start_timestep = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start_timestep = 1'b0;
        check("clear_pulse", 32'(bus.clear_adder), 1);
        check("busy_sweep", 32'(busy), 1);
        for (int n = 0; n < int'(N); n++) begin
            k = 0;
            while (!bus.weight_req && k < 20) begin @(negedge clk); k++; end
            check("weight_req", 32'(bus.weight_req), 1);
            check("neuron_idx", 32'(bus.neuron_idx), 32'(n));
            if (n == stop_at) return;
            if (n == 1) check("clear_drop", 32'(bus.clear_adder), 0);
            if (n == delay_n) begin
                repeat (delay_cycles) begin
                    @(negedge clk);
                    check("req_hold", 32'(bus.weight_req), 1);
                    check("idx_hold", 32'(bus.neuron_idx), 32'(n));
                    check("weight_hold", bus.input_weight, w(t, n - 1));
                    check("dec_hold", bus.decayed_potential, exp_dec(t, n - 1));
                end
            end
            bus.weight_valid = 1'b1;
            bus.weight_data  = w(t, n);
            @(negedge clk);
            bus.weight_valid = 1'b0;
            bus.weight_data  = 32'hDEAD_BEEF;
            check("req_drop", 32'(bus.weight_req), 0);
            check($sformatf("dec_t%0d_n%0d", t, n), bus.decayed_potential, exp_dec(t, n));
            check("weight_op", bus.input_weight, w(t, n));
            if (n == int'(N) - 1) check("vec_stable", 32'(spike_vec), exp_vec(t - 1));
            if (t == 2 && n == 10) begin
                start_timestep = 1'b1;
                @(negedge clk);
                start_timestep = 1'b0;
            end
        end
        k = 0;
        while (!done && k < 20) begin @(negedge clk); k++; end
        check("sweep_done", 32'(done), 1);
        check("sweep_len", 32'(cyc - c0 + 1), 32'(N * (3 + L) + 2 + delay_cycles));
        check($sformatf("spike_vec_t%0d", t), 32'(spike_vec), exp_vec(t));
        @(negedge clk);
        check("done_pulse", 32'(done), 0);
        check("idle_after", 32'(busy), 0);
        @(negedge clk);
        check("no_requeue", 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.weight_valid = 1'b0;
        bus.weight_data  = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_req", 32'(bus.weight_req), 0);
        check("rst_set", 32'(bus.set_adder), 0);
        check("rst_dec", bus.decayed_potential, 32'h0);
        rst_n = 1'b1;
        wait_init(N);

        run_timestep(1, -1, 0, -1);
        run_timestep(2, -1, 0, -1);
        run_timestep(3, 7, 5, -1);
        run_timestep(4, -1, 0, 12);

        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_req", 32'(bus.weight_req), 0);
        check("midrst_vec", 32'(spike_vec), 0);
        check("midrst_dec", bus.decayed_potential, 32'h0);
        check("midrst_w", bus.input_weight, 32'h0);
        check("midrst_idx", 32'(bus.neuron_idx), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init(N);

        init_req = 1'b1;
        start_timestep = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
        start_timestep = 1'b0;
        check("prio_no_clear", 32'(bus.clear_adder), 0);
        check("prio_busy", 32'(busy), 1);
        wait_init(N);

        run_timestep(5, -1, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
